// File: rtl/vga_trace_buffer_if.sv
// Bundles the snooped VGA write port and the debug read port of vga_trace_buffer.
// master = processor/debug-host side, slave = the trace buffer itself.
interface vga_trace_buffer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int TS_W   = 16
);
  logic              vga_we;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              rd_req;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [TS_W-1:0]   rd_stamp;

  modport master (
    output vga_we, vga_addr, vga_data, rd_req,
    input  rd_valid, rd_addr, rd_data, rd_stamp
  );

  modport slave (
    input  vga_we, vga_addr, vga_data, rd_req,
    output rd_valid, rd_addr, rd_data, rd_stamp
  );
endinterface

// File: rtl/vga_trace_buffer.sv
// Timestamped circular capture buffer for VGA write strobes with a pop-style read port.
// Optional feature macro TRACE_DEDUP_EN suppresses captures repeating the last accepted {addr, data}.
module vga_trace_buffer #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     cap_en,
  input  logic                     wrap_mode,
  vga_trace_buffer_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   stamp;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            rdEntry_q, rdEntry_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              overflow_q, overflow_d, rdValid_q, rdValid_d;
  logic [15:0]       dropCnt_q, dropCnt_d;
  logic [TS_W-1:0]   stampCnt_q;
  logic              isDup, capture, pop, writeMem, grow;

`ifdef TRACE_DEDUP_EN
  logic                     lastValid_q;
  logic [ADDR_W+DATA_W-1:0] last_q;

  assign isDup = lastValid_q && (last_q == {bus.vga_addr, bus.vga_data});

  // Remembers the most recently accepted capture so back-to-back repeats are dropped silently.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lastValid_q <= 1'b0;
      last_q      <= '0;
    end else if (clear) begin
      lastValid_q <= 1'b0;
    end else if (capture) begin
      lastValid_q <= 1'b1;
      last_q      <= {bus.vga_addr, bus.vga_data};
    end
  end
`else
  assign isDup = 1'b0;
`endif

  assign capture  = bus.vga_we & cap_en & ~isDup;
  assign pop      = bus.rd_req & ~empty_q;
  // A same-edge pop frees the slot, so a full buffer still accepts the write without a drop.
  assign grow     = capture & (~full_q | pop);
  assign writeMem = capture & (~full_q | pop | wrap_mode) & ~clear;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    overflow_d = overflow_q;
    dropCnt_d  = dropCnt_q;
    rdValid_d  = 1'b0;
    rdEntry_d  = rdEntry_q;
    count_d    = count_q + {{PTR_W{1'b0}}, grow} - {{PTR_W{1'b0}}, pop};
    if (pop) begin
      rdEntry_d = mem_q[rdPtr_q];
      rdValid_d = 1'b1;
      rdPtr_d   = rdPtr_q + PTR_W'(1);
    end
    if (writeMem) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (capture && full_q && !pop) begin
      overflow_d = 1'b1;
      if (dropCnt_q != 16'hFFFF) begin
        dropCnt_d = dropCnt_q + 16'd1;
      end
      if (wrap_mode) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
    end
    if (clear) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      dropCnt_d  = '0;
      rdValid_d  = 1'b0;
      rdEntry_d  = rdEntry_q;
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
      rdValid_q  <= 1'b0;
      rdEntry_q  <= '0;
      stampCnt_q <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
      rdValid_q  <= rdValid_d;
      rdEntry_q  <= rdEntry_d;
      stampCnt_q <= stampCnt_q + TS_W'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (writeMem) begin
      mem_q[wrPtr_q] <= '{addr: bus.vga_addr, data: bus.vga_data, stamp: stampCnt_q};
    end
  end

  assign bus.rd_valid = rdValid_q;
  assign bus.rd_addr  = rdEntry_q.addr;
  assign bus.rd_data  = rdEntry_q.data;
  assign bus.rd_stamp = rdEntry_q.stamp;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = dropCnt_q;
endmodule

// File: doc/vga_trace_buffer.md
# vga_trace_buffer

Synthesizable capture buffer for the processor's VGA write port, replacing simulation-only `$monitor` tracing of VGA enable, address and data with an on-chip, parametrised, timestamped record. Sits beside the processor on the same clock, snoops every VGA write strobe, and stores events in a DEPTH-entry circular buffer. A debug host drains the buffer through a simple request/valid read port. The buffer has two full-policies: stop-when-full and wrap/overwrite-oldest.

## Interface
- ADDR_W, 19, VGA address width
- DATA_W, 8, VGA pixel data width
- DEPTH, 16, entries; power of two, ≥2
- TS_W, 16, timestamp width
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- clear  in  1  synchronous flush
- cap_en  in  1  capture armed
- wrap_mode  in  1  0 = stop-when-full, 1 = overwrite oldest
- vga_we  in  1  VGA write strobe from processor
- vga_addr  in  ADDR_W  VGA write address
- vga_data  in  DATA_W  VGA write data
- rd_req  in  1  pop request
- rd_valid  out  1  popped entry valid, one-cycle pulse
- rd_addr  out  ADDR_W  popped address
- rd_data  out  DATA_W  popped data
- rd_stamp  out  TS_W  popped timestamp
- count  out  log2(DEPTH)+1  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky; an event was dropped or overwritten
- drop_cnt  out  16  saturating lost-event count

## Operation
- Capture event: `vga_we & cap_en` sampled on a rising edge.
- Each entry holds {vga_addr, vga_data, stamp}. The stamp is the free-running counter value at the capture edge, taken before that edge's increment.
- Stamp counter: TS_W bits, 0 after reset, +1 every cycle, wraps modulo 2^TS_W. Unaffected by `clear`.
- Write pointer, read pointer: log2(DEPTH) bits, wrap naturally.
- Capture, not full: entry written at wptr; wptr+1; count+1.
- Capture, full, wrap_mode=0: event discarded; overflow←1; drop_cnt+1, saturating at 0xFFFF.
- Capture, full, wrap_mode=1: entry overwrites the oldest; wptr+1, rptr+1; count stays DEPTH; overflow←1; drop_cnt+1, saturating.
- Pop (rd_req & !empty): the entry at rptr drives rd_* on the next cycle with rd_valid=1; rptr+1; count−1.
- rd_req while empty: ignored. rd_valid=0 and rd_* hold their previous values.
- Capture and pop on the same edge:
  - Not full: both occur and count is unchanged. When empty, the pop is ignored and the capture proceeds.
  - Full, wrap_mode=1: the pop returns the oldest entry, the new entry is written, and rptr advances once. Count becomes DEPTH.
  - Full, wrap_mode=0: the pop and the write both succeed, count stays DEPTH, and no drop is recorded.
- clear: wptr, rptr, count, overflow and drop_cnt go to 0; rd_valid←0. Clear takes priority over a capture or pop on the same edge.
- wrap_mode and cap_en take effect on the edge where they are sampled. Buffer contents are unaffected.

## Timing
- Reset values: rd_valid=0, rd_addr=0, rd_data=0, rd_stamp=0, count=0, full=0, empty=1, overflow=0, drop_cnt=0, stamp counter=0.
- Reset asserted mid-operation clears everything immediately, asynchronously. Operation resumes on the first edge after deassertion.
- Capture-to-visibility latency: count, full and empty update one cycle after the capture edge. The entry can be popped from that edge onward.
- Pop latency: 1 cycle from the rd_req edge to rd_valid.
- Throughput: one capture and one pop per cycle.
- full, empty, count and overflow are registered.

## Configuration
- TRACE_DEDUP_EN defined:
  - A capture whose {vga_addr, vga_data} equals the last accepted capture is suppressed. No write and no drop count.
  - The last-accepted register resets and clears to an invalid state, so the first capture is always accepted.
- TRACE_DEDUP_EN undefined: every capture event is processed.

## Test plan
- Reset low, then high; cap_en=1; 3 strokes (addr 5/6/7, data 0x11/0x22/0x33) at cycles 10, 11, 12; pop ×3 → entries in order, stamps 10, 11, 12; then empty=1.
- wrap_mode=0, DEPTH=16; 20 captures → count=16, overflow=1, drop_cnt=4; pops return captures 0–15.
- wrap_mode=1; 20 captures → count=16, drop_cnt=4; pops return captures 4–19.
- Full buffer with simultaneous capture and pop in both modes → count stays 16, rd_valid=1, no drop recorded in either mode; rd_req on an empty buffer → rd_valid=0.
- With TRACE_DEDUP_EN, 4 identical writes (addr 9, data 0xAA) then addr 9 with data 0xAB → count=2. Without the macro → count=5.
- Reset pulsed low mid-stream with count=7 → all outputs at reset values within the same cycle; the next capture lands with count=1.
